hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// - Central hazard/sequencing unit for the 5-stage RV32I pipeline. Drives the enable (~stall) and clear (flush)
//   inputs of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand-forwarding selects.
// - Handles load-use stalls, taken branch/jump flushes and multi-cycle data-memory wait states; detects dmem timeouts.
// PARAMETERS
// - MAX_WAIT  255  max consecutive cycles in WAIT before timeout (1..65535)
// - WAIT_W    $clog2(MAX_WAIT+1)  wait counter width (derived, localparam)
// PORTS
// - clk           in   1   clock
// - rst_n         in   1   reset, synchronous, active-low
// - rs1_d, rs2_d  in   5   source regs of instruction in D
// - rs1_e, rs2_e  in   5   source regs of instruction in E
// - rd_e          in   5   dest reg in E;  result_src_e in 2: E-stage ResultSrc (2'b01 = load)
// - rd_m, rd_w    in   5   dest regs in M / W;  reg_write_m, reg_write_w in 1: RegWrite in M / W
// - pc_src_e      in   1   taken branch or jump resolved in E
// - mem_access_m  in   1   load/store in M requests dmem this cycle
// - dmem_ready    in   1   dmem completes the M-stage access this cycle
// - stall_f, stall_d, stall_e, stall_m, stall_w  out 1  hold the stage register (enable = ~stall)
// - flush_d, flush_e  out 1  clear F/D and D/E registers (insert bubble)
// - fwd_a_e, fwd_b_e  out 2  00 regfile, 10 from M ALU result, 01 from W result, 11 unused
// - mem_timeout   out  1   sticky timeout flag
// BEHAVIOUR
// - FSM states: RUN, WAIT, TIMEOUT. Reset: state=RUN, wait_cnt=0, mem_timeout=0.
// - During reset (rst_n=0): all stall/flush = 0, fwd = 00 (pipeline registers self-reset).
// - RUN -> WAIT when mem_access_m && !dmem_ready; wait_cnt <= 1.
// - WAIT: wait_cnt++ each cycle; -> RUN on dmem_ready (wait_cnt <= 0); -> TIMEOUT when wait_cnt == MAX_WAIT && !dmem_ready.
// - TIMEOUT: mem_timeout=1, all stalls=1, no flush; exit only via reset.
// - freeze = (RUN && mem_access_m && !dmem_ready) || WAIT&&!dmem_ready || TIMEOUT. Combinational, same cycle.
// - freeze: stall_f..stall_w all 1, flush_d=flush_e=0 (a branch in E stays pending, flushes on release cycle).
// - Load-use (no freeze): result_src_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d)
//   -> stall_f=stall_d=1, flush_e=1, stall_e/m/w=0. Exactly one bubble.
// - Control (no freeze): pc_src_e -> flush_d=flush_e=1, no stalls. If load-use also true, flush wins, stall_f/d=0.
// - Forwarding (all states, combinational): M if reg_write_m && rd_m!=0 && rd_m==rs_e; else W if
//   reg_write_w && rd_w!=0 && rd_w==rs_e; else 00. M has priority over W. x0 never forwarded or stalled on.
// - Latency: all stall/flush/fwd outputs are combinational from inputs + current state; zero cycle.
// - Release cycle (WAIT with dmem_ready): freeze=0, normal load-use/control evaluation that cycle.
// - MAX_WAIT=1: a single not-ready WAIT cycle times out.
// CONFIGURATION
// - HAZARD_PERF_CNT_EN defined: adds outputs perf_load_stall, perf_flush, perf_mem_wait (32 b each), counting
//   cycles with load-use stall applied, flush_e from pc_src_e, and freeze=1; wrap at 2^32; reset to 0.
// - Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - hazard_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}, haz_state_e {RUN, WAIT, TIMEOUT},
//   RESULT_SRC_LOAD = 2'b01.
// - Sub-module forward_unit (purely combinational, instantiated twice for operands A and B).
// TESTING
// - Load-use: lw x5 in E (rd_e=5, result_src_e=01), rs1_d=5 -> stall_f=stall_d=1, flush_e=1 one cycle; then 0.
// - Forwarding: rd_m=rd_w=7, both reg_write, rs1_e=7 -> fwd_a_e=10; reg_write_m=0 -> 01; rs1_e=0, rd_m=0 -> 00.
// - Branch: pc_src_e=1 with load-use also true -> flush_d=flush_e=1, stall_f=stall_d=0.
// - Mem wait: mem_access_m=1, dmem_ready low 3 cycles then high -> stalls=1 for 3 cycles, WAIT entered,
//   RUN on 4th; pending pc_src_e flushes only on release cycle.
// - Timeout: MAX_WAIT=4, dmem_ready held 0 -> mem_timeout=1 after wait_cnt reaches 4, all stalls stay 1;
//   rst_n=0 for 1 cycle clears state, flag, and counters.
// - With HAZARD_PERF_CNT_EN: preload perf_mem_wait near 2^32-1 via force -> wraps to 0; counts match events above.

Source files
------------

// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the RV32I hazard/sequencing unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hazard_pkg;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Data-memory sequencing state
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    TIMEOUT = 2'b10
  } haz_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // True when a destination register really produces the named source; x0 never matches
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Purpose: pick the freshest in-flight producer of one E-stage source operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; always produces a select.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_e   fwd_sel
);

  // M holds the younger result, so it wins over W
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && reg_match(rd_m, rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && reg_match(rd_w, rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Purpose: 5-stage pipeline stall/flush/forward control with dmem wait-state sequencing and timeout.
// Latency: all outputs combinational from inputs and current state (zero cycles); state updates on clk.
// Backpressure: a dmem not-ready freezes every stage; HAZARD_PERF_CNT_EN adds event counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       pc_src_e,
  input  logic       mem_access_m,
  input  logic       dmem_ready,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       stall_w,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_load_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_mem_wait
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  haz_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              freeze;
  logic              load_use;
  fwd_sel_e          fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_b)
  );

  // Pipeline registers reset themselves, so forwarding is forced to the regfile during reset
  assign fwd_a_e     = rst_n ? fwd_a : FWD_RF;
  assign fwd_b_e     = rst_n ? fwd_b : FWD_RF;
  assign mem_timeout = rst_n && (state_q == TIMEOUT);

  assign load_use = (result_src_e == RESULT_SRC_LOAD) &&
                    (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state plus stall/flush decode; freeze beats control flush beats load-use
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    stall_w    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_access_m && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          // Release cycle: pipeline moves and normal hazard rules apply
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
            state_d = TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      TIMEOUT: begin
        freeze = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (freeze) begin
      // A branch resolved in E stays put and flushes once the freeze lifts
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (pc_src_e) begin
      // Wrong-path instructions in F/D and D/E are discarded; a load-use stall would be moot
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in D for one cycle and send a bubble into E
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end

    if (!rst_n) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_mem_wait_q;

  // Event counters: stall_e is only raised by a freeze, flush_d only by a taken branch/jump
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_load_stall_q <= '0;
      perf_flush_q      <= '0;
      perf_mem_wait_q   <= '0;
    end else begin
      if (stall_d && !stall_e) perf_load_stall_q <= perf_load_stall_q + 32'd1;
      if (flush_d)             perf_flush_q      <= perf_flush_q + 32'd1;
      if (freeze)              perf_mem_wait_q   <= perf_mem_wait_q + 32'd1;
    end
  end

  assign perf_load_stall = perf_load_stall_q;
  assign perf_flush      = perf_flush_q;
  assign perf_mem_wait   = perf_mem_wait_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Purpose: directed stimulus for hazard_controller with a cycle-by-cycle reference model.
// Latency: outputs checked mid-cycle against the model and against hand-computed literals.
// Backpressure: dmem wait and timeout sequences exercised with MAX_WAIT=4.
module tb_hazard_controller;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       reg_write_m, reg_write_w, pc_src_e, mem_access_m, dmem_ready;
  logic       stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, mem_timeout;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_stall, perf_flush, perf_mem_wait;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.MAX_WAIT(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .result_src_e (result_src_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_access_m (mem_access_m),
    .dmem_ready   (dmem_ready),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .stall_w      (stall_w),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_load_stall (perf_load_stall),
    .perf_flush      (perf_flush),
    .perf_mem_wait   (perf_mem_wait)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: count of consecutive not-ready memory cycles, a sticky timeout, event tallies
  int          nr = 0;
  bit          to = 1'b0;
  logic [31:0] m_ls = '0, m_fl = '0, m_mw = '0;
  bit          preload = 1'b0;
  bit          cmp_en = 1'b0;

  logic pending, e_freeze, e_lu, e_sf, e_sd, e_sx, e_fd, e_fe;
  logic [1:0] e_fa, e_fb;

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the hazard rules
  always_comb begin
    pending  = (nr == 0) ? (mem_access_m && !dmem_ready) : !dmem_ready;
    e_freeze = rst_n && (to || pending);
    e_lu     = result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    e_sf = 0; e_sd = 0; e_sx = 0; e_fd = 0; e_fe = 0; e_fa = 2'b00; e_fb = 2'b00;
    if (rst_n) begin
      e_fa = fsel(rs1_e);
      e_fb = fsel(rs2_e);
      if (e_freeze) begin
        e_sf = 1; e_sd = 1; e_sx = 1;
      end else if (pc_src_e) begin
        e_fd = 1; e_fe = 1;
      end else if (e_lu) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
    end
  end

  // Model state advance
  always @(posedge clk) begin
    if (!rst_n) begin
      nr <= 0; to <= 1'b0; m_ls <= '0; m_fl <= '0; m_mw <= '0;
    end else begin
      nr <= to ? nr : (pending ? nr + 1 : 0);
      to <= to || (pending && (nr + 1 > MW));
      if (e_sf && !e_sx) m_ls <= m_ls + 1;
      if (e_fd)          m_fl <= m_fl + 1;
      if (preload)       m_mw <= 32'hFFFF_FFFE + (e_freeze ? 32'd1 : 32'd0);
      else if (e_freeze) m_mw <= m_mw + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_stall_f", stall_f, e_sf);
      chk("m_stall_d", stall_d, e_sd);
      chk("m_stall_emw", {stall_e, stall_m, stall_w}, {3{e_sx}});
      chk("m_flush_d", flush_d, e_fd);
      chk("m_flush_e", flush_e, e_fe);
      chk("m_fwd_a", fwd_a_e, e_fa);
      chk("m_fwd_b", fwd_b_e, e_fb);
      chk("m_timeout", mem_timeout, rst_n && to);
`ifdef HAZARD_PERF_CNT_EN
      chk("m_perf_ls", perf_load_stall, m_ls);
      chk("m_perf_fl", perf_flush, m_fl);
      chk("m_perf_mw", perf_mem_wait, preload ? 32'hFFFF_FFFE : m_mw);
`endif
    end
  end

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
    mem_access_m = 0; dmem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Hazards asserted during reset must be masked
    rd_m = 7; rs1_e = 7; reg_write_m = 1; pc_src_e = 1; result_src_e = 2'b01;
    rd_e = 5; rs1_d = 5; mem_access_m = 1;
    cyc(); cmp_en = 1'b1; #2;
    chk("rst_stall_f", stall_f, 0);
    chk("rst_flush_e", flush_e, 0);
    chk("rst_fwd_a", fwd_a_e, 2'b00);
    chk("rst_timeout", mem_timeout, 0);

    cyc(); idle(); rst_n = 1'b1; #2;
    chk("idle_stall_f", stall_f, 0);

    // Load-use on rs1
    cyc(); result_src_e = 2'b01; rd_e = 5; rs1_d = 5; #2;
    chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    chk("lu_flush_e", flush_e, 1);
    chk("lu_stall_e", stall_e, 0);
    chk("lu_flush_d", flush_d, 0);
    cyc(); idle(); rs1_d = 5; #2;
    chk("lu_bubble_stall_f", stall_f, 0);
    chk("lu_bubble_flush_e", flush_e, 0);
    // Load-use on rs2, x0 never stalls, ALU producer never stalls
    cyc(); idle(); result_src_e = 2'b01; rd_e = 9; rs2_d = 9; #2;
    chk("lu_rs2_stall_d", stall_d, 1);
    cyc(); idle(); result_src_e = 2'b01; rd_e = 0; rs1_d = 0; #2;
    chk("lu_x0_stall_f", stall_f, 0);
    cyc(); idle(); result_src_e = 2'b00; rd_e = 5; rs1_d = 5; #2;
    chk("lu_alu_stall_f", stall_f, 0);

    // Forwarding priority
    cyc(); idle(); rd_m = 7; rd_w = 7; reg_write_m = 1; reg_write_w = 1; rs1_e = 7; rs2_e = 7; #2;
    chk("fwd_m_a", fwd_a_e, 2'b10);
    chk("fwd_m_b", fwd_b_e, 2'b10);
    cyc(); reg_write_m = 0; #2;
    chk("fwd_w_a", fwd_a_e, 2'b01);
    cyc(); idle(); reg_write_m = 1; reg_write_w = 1; rd_m = 0; rs1_e = 0; rd_w = 3; rs2_e = 3; #2;
    chk("fwd_x0_a", fwd_a_e, 2'b00);
    chk("fwd_w3_b", fwd_b_e, 2'b01);

    // Branch wins over load-use
    cyc(); idle(); pc_src_e = 1; result_src_e = 2'b01; rd_e = 5; rs1_d = 5; #2;
    chk("br_flush_d", flush_d, 1);
    chk("br_flush_e", flush_e, 1);
    chk("br_stall_f", stall_f, 0);
    chk("br_stall_d", stall_d, 0);

    // Three dmem wait cycles with a pending branch, then release
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); mem_access_m = 1; pc_src_e = 1; #2;
      chk("mw_stalls", {stall_f, stall_d, stall_e, stall_m, stall_w}, 5'b11111);
      chk("mw_flush", {flush_d, flush_e}, 2'b00);
    end
    cyc(); idle(); mem_access_m = 1; dmem_ready = 1; pc_src_e = 1; #2;
    chk("rel_stall_w", stall_w, 0);
    chk("rel_flush_d", flush_d, 1);
    chk("rel_flush_e", flush_e, 1);
    cyc(); idle(); #2;
    chk("post_rel_stall_f", stall_f, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_ls_lit", perf_load_stall, 32'd2);
    chk("perf_fl_lit", perf_flush, 32'd2);
    chk("perf_mw_lit", perf_mem_wait, 32'd3);
    force dut.perf_mem_wait_q = 32'hFFFF_FFFE;
    preload = 1'b1;
    #1;
    release dut.perf_mem_wait_q;
`endif

    // Timeout: one RUN not-ready cycle plus MW WAIT cycles
    for (int i = 0; i < 1 + MW; i++) begin
      cyc(); preload = 1'b0; idle(); mem_access_m = 1; #2;
      chk("to_stall_f", stall_f, 1);
      chk("to_flag_early", mem_timeout, 0);
    end
    cyc(); idle(); dmem_ready = 1; pc_src_e = 1; #2;
    chk("to_flag", mem_timeout, 1);
    chk("to_stalls", {stall_f, stall_d, stall_e, stall_m, stall_w}, 5'b11111);
    chk("to_no_flush", flush_d, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_mw_wrap", perf_mem_wait, 32'd3);
`endif
    cyc(); idle(); dmem_ready = 1; #2;
    chk("to_sticky", mem_timeout, 1);

    cyc(); rst_n = 1'b0; #2;
    chk("rst2_stall_f", stall_f, 0);
    chk("rst2_timeout", mem_timeout, 0);
    cyc(); rst_n = 1'b1; idle(); #2;
    chk("rst2_after_timeout", mem_timeout, 0);
    chk("rst2_after_stall_m", stall_m, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst2_perf", perf_load_stall | perf_flush | perf_mem_wait, 32'd0);
`endif

    cyc(); cmp_en = 1'b0; #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
